// File: rtl/mig_pkg.sv
// Shared MIG user-port constants and the p0 write burster state encoding.
package mig_pkg;

  localparam logic [2:0] WR    = 3'b000;
  localparam logic [2:0] RD    = 3'b001;
  localparam logic [2:0] WR_AP = 3'b010;
  localparam logic [2:0] RD_AP = 3'b011;

  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int ADDR_W = 30;
  localparam int BL_W   = 6;
  localparam int CNT_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LAST,
    ST_CMD,
    ST_DRAIN
  } burst_state_t;

endpackage

// File: rtl/mig_p0_write_burster.sv
// Streams 64-bit pixel words into the MIG p0 write FIFO and issues one write
// command per burst, walking a wrapping frame-buffer address.
module mig_p0_write_burster
  import mig_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 38400,
  parameter int unsigned DRAIN_GUARD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              calib_done,
  input  logic              frame_start,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              c3_p0_wr_en,
  output logic [DATA_W-1:0] c3_p0_wr_data,
  output logic [MASK_W-1:0] c3_p0_wr_mask,
  input  logic [CNT_W-1:0]  c3_p0_wr_count,
  output logic              c3_p0_cmd_en,
  output logic [2:0]        c3_p0_cmd_instr,
  output logic [BL_W-1:0]   c3_p0_cmd_bl,
  output logic [ADDR_W-1:0] c3_p0_cmd_byte_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  burst_state_t      state, state_next;
  logic [6:0]        n, n_inc, limit;
  logic [31:0]       words_done, remaining, done_sum;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        guard;
  logic              guard_ok, flush_pend, start_pend, flush_eff, start_eff;
  logic              accept, restart_now, frame_wrap;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;

  // The last burst of a frame is shortened so it never runs past the buffer end.
  assign remaining   = FRAME_WORDS - words_done;
  assign limit       = (remaining < BURST_LEN) ? remaining[6:0] : 7'(BURST_LEN);
  assign s_ready     = (state == ST_FILL) && calib_done && (n < limit);
  assign accept      = s_valid && s_ready;
  assign n_inc       = n + {6'd0, accept};
  assign flush_eff   = flush || flush_pend;
  assign start_eff   = frame_start || start_pend;
  assign done_sum    = words_done + 32'(n);
  assign frame_wrap  = done_sum >= FRAME_WORDS;
  assign guard_ok    = (32'(guard) + 32'd1) >= DRAIN_GUARD;
  assign restart_now = start_eff && ((state == ST_IDLE) || ((state == ST_FILL) && (n == 7'd0)));

  always_comb begin
    state_next   = state;
    c3_p0_cmd_en = 1'b0;
    frame_done   = 1'b0;
    case (state)
      ST_IDLE:  if (calib_done) state_next = ST_FILL;
      ST_FILL:  if (calib_done && ((accept && (n_inc == limit)) ||
                                   (flush_eff && (n_inc != 7'd0))))
                  state_next = ST_LAST;
      ST_LAST:  state_next = ST_CMD;
      ST_CMD: begin
        state_next   = ST_DRAIN;
        c3_p0_cmd_en = 1'b1;
        frame_done   = frame_wrap;
      end
      ST_DRAIN: if (guard_ok && (c3_p0_wr_count == '0)) state_next = ST_FILL;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      n          <= '0;
      words_done <= '0;
      addr       <= BASE;
      guard      <= '0;
      flush_pend <= 1'b0;
      start_pend <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state   <= state_next;
      wr_en_q <= accept;
      if (accept) wr_data_q <= s_data;

      // A flush only survives while calibration stalls a non-empty burst.
      flush_pend <= (state == ST_FILL) && !calib_done && (n != 7'd0) && flush_eff;

      case (state)
        ST_FILL: n <= n_inc;
        ST_CMD:  n <= '0;
        default: ;
      endcase

      if (state == ST_CMD) guard <= '0;
      else if ((state == ST_DRAIN) && !guard_ok) guard <= guard + 8'd1;

      if (restart_now) begin
        addr       <= BASE;
        words_done <= '0;
        start_pend <= 1'b0;
      end else if (state == ST_CMD) begin
        start_pend <= 1'b0;
        if (frame_wrap || start_eff) begin
          addr       <= BASE;
          words_done <= '0;
        end else begin
          addr       <= addr + ADDR_W'({n, 3'b000});
          words_done <= done_sum;
        end
      end else begin
        start_pend <= start_eff;
      end
    end
  end

  assign c3_p0_wr_en         = wr_en_q;
  assign c3_p0_wr_data       = wr_data_q;
  assign c3_p0_wr_mask       = '0;
  assign c3_p0_cmd_instr     = WR;
  assign c3_p0_cmd_bl        = (state == ST_CMD) ? BL_W'(n - 7'd1) : '0;
  assign c3_p0_cmd_byte_addr = addr;
  assign busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_mig_p0_write_burster.sv
// Directed bench for mig_p0_write_burster with a small MIG write-FIFO model.
module tb_mig_p0_write_burster;

  typedef struct {
    logic [29:0] addr;
    logic [5:0]  bl;
    logic [2:0]  instr;
    logic        fd;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        calib_done = 1'b0, frame_start = 1'b0, flush = 1'b0, s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready, c3_p0_wr_en, c3_p0_cmd_en, busy, frame_done;
  logic [63:0] c3_p0_wr_data;
  logic [7:0]  c3_p0_wr_mask;
  logic [6:0]  c3_p0_wr_count;
  logic [2:0]  c3_p0_cmd_instr;
  logic [5:0]  c3_p0_cmd_bl;
  logic [29:0] c3_p0_cmd_byte_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mig_p0_write_burster #(
    .BURST_LEN(8), .BASE_ADDR(0), .FRAME_WORDS(20), .DRAIN_GUARD(4)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .frame_start(frame_start),
    .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .c3_p0_wr_en(c3_p0_wr_en), .c3_p0_wr_data(c3_p0_wr_data), .c3_p0_wr_mask(c3_p0_wr_mask),
    .c3_p0_wr_count(c3_p0_wr_count), .c3_p0_cmd_en(c3_p0_cmd_en),
    .c3_p0_cmd_instr(c3_p0_cmd_instr), .c3_p0_cmd_bl(c3_p0_cmd_bl),
    .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr), .busy(busy), .frame_done(frame_done)
  );

  // MIG FIFO model: occupancy counts pushes and empties drain_delay cycles after a command.
  int unsigned drain_delay = 6;
  int unsigned dtimer = 0;
  logic [6:0]  occ = '0;
  assign c3_p0_wr_count = occ;

  always @(posedge clk) begin
    if (reset) begin
      occ <= '0;
      dtimer <= 0;
    end else begin
      if (c3_p0_cmd_en) dtimer <= drain_delay;
      else if (dtimer > 0) dtimer <= dtimer - 1;
      if (dtimer == 1) occ <= '0;
      else if (c3_p0_wr_en) occ <= occ + 7'd1;
    end
  end

  int          cyc = 0;
  logic [63:0] wr_q[$];
  cmd_t        cmd_q[$];
  int          gap_q[$];
  int          cmd_cyc = 0;
  bit          cmd_seen = 0, ready_prev = 0;
  int          n_ready = 0, n_wr = 0, n_cmd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c3_p0_wr_en) begin wr_q.push_back(c3_p0_wr_data); n_wr++; end
    if (c3_p0_cmd_en) begin
      cmd_q.push_back('{c3_p0_cmd_byte_addr, c3_p0_cmd_bl, c3_p0_cmd_instr, frame_done});
      cmd_cyc = cyc;
      cmd_seen = 1;
      n_cmd++;
    end
    if (s_ready) n_ready++;
    if (s_ready && !ready_prev && cmd_seen) begin
      gap_q.push_back(cyc - cmd_cyc);
      cmd_seen = 0;
    end
    ready_prev = s_ready;
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    cmd_q.delete();
    gap_q.delete();
    cmd_seen = 0;
    n_ready = 0;
    n_wr = 0;
    n_cmd = 0;
  endtask

  task automatic do_reset(input logic calib);
    calib_done = calib;
    reset = 1'b1;
    s_valid = 1'b0;
    flush = 1'b0;
    frame_start = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic push_word(input logic [63:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      cycle();
    end
    s_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout: word %0d never accepted", d);
    end
  endtask

  task automatic push_run(input int first, input int count);
    for (int i = 0; i < count; i++) push_word(64'(first + i));
  endtask

  task automatic wait_cmds(input int n);
    for (int i = 0; i < 400 && cmd_q.size() < n; i++) cycle();
    checks++;
    if (cmd_q.size() != n) begin
      errors++;
      $display("FAIL cmd_count: got %0d required %0d", cmd_q.size(), n);
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      cycle();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ready_timeout: s_ready never rose"); end
  endtask

  task automatic test_reset();
    calib_done = 1'b1;
    s_valid = 1'b1;
    s_data = 64'hDEAD;
    reset = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    checks += 10;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
    if (c3_p0_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", c3_p0_wr_en); end
    if (c3_p0_wr_data !== 64'd0) begin errors++; $display("FAIL rst_wr_data: got %0h required 0", c3_p0_wr_data); end
    if (c3_p0_wr_mask !== 8'd0) begin errors++; $display("FAIL rst_mask: got %0h required 0", c3_p0_wr_mask); end
    if (c3_p0_cmd_en !== 1'b0) begin errors++; $display("FAIL rst_cmd_en: got %b required 0", c3_p0_cmd_en); end
    if (c3_p0_cmd_instr !== 3'd0) begin errors++; $display("FAIL rst_instr: got %0d required 0", c3_p0_cmd_instr); end
    if (c3_p0_cmd_bl !== 6'd0) begin errors++; $display("FAIL rst_bl: got %0d required 0", c3_p0_cmd_bl); end
    if (c3_p0_cmd_byte_addr !== 30'd0) begin errors++; $display("FAIL rst_addr: got %0h required 0", c3_p0_cmd_byte_addr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    s_valid = 1'b0;
    reset = 1'b0;
    cycle();
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL idle_to_fill_busy: got %b required 1", busy); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_to_fill_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_no_calib();
    do_reset(1'b0);
    s_valid = 1'b1;
    s_data = 64'h55;
    repeat (100) cycle();
    s_valid = 1'b0;
    checks += 4;
    if (n_ready !== 0) begin errors++; $display("FAIL nocal_ready: got %0d cycles required 0", n_ready); end
    if (n_wr !== 0) begin errors++; $display("FAIL nocal_wr_en: got %0d required 0", n_wr); end
    if (n_cmd !== 0) begin errors++; $display("FAIL nocal_cmd_en: got %0d required 0", n_cmd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL nocal_busy: got %b required 0", busy); end
  endtask

  // Frame of 20 words: bursts 8/8/4, wrap, then a fresh burst from the base.
  task automatic test_frame();
    logic [29:0] ea[4];
    logic [5:0]  eb[4];
    logic        ef[4];
    ea = '{30'd0, 30'd64, 30'd128, 30'd0};
    eb = '{6'd7, 6'd7, 6'd3, 6'd7};
    ef = '{1'b0, 1'b0, 1'b1, 1'b0};
    drain_delay = 6;
    do_reset(1'b1);
    push_run(20, 28);
    wait_cmds(4);
    for (int i = 0; i < cmd_q.size() && i < 4; i++) begin
      checks += 4;
      if (cmd_q[i].addr !== ea[i]) begin errors++; $display("FAIL frame_addr[%0d]: got %0d required %0d", i, cmd_q[i].addr, ea[i]); end
      if (cmd_q[i].bl !== eb[i]) begin errors++; $display("FAIL frame_bl[%0d]: got %0d required %0d", i, cmd_q[i].bl, eb[i]); end
      if (cmd_q[i].fd !== ef[i]) begin errors++; $display("FAIL frame_done[%0d]: got %b required %b", i, cmd_q[i].fd, ef[i]); end
      if (cmd_q[i].instr !== 3'b000) begin errors++; $display("FAIL frame_instr[%0d]: got %0d required 0", i, cmd_q[i].instr); end
    end
    checks++;
    if (wr_q.size() != 28) begin errors++; $display("FAIL frame_wr_count: got %0d required 28", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 28; i++) begin
      checks++;
      if (wr_q[i] !== 64'(20 + i)) begin errors++; $display("FAIL frame_wr_data[%0d]: got %0d required %0d", i, wr_q[i], 20 + i); end
    end
    checks++;
    if (gap_q.size() < 3) begin errors++; $display("FAIL frame_gap_count: got %0d required 3", gap_q.size()); end
    for (int i = 0; i < gap_q.size() && i < 3; i++) begin
      checks++;
      if (gap_q[i] !== 8) begin errors++; $display("FAIL frame_drain_gap[%0d]: got %0d required 8", i, gap_q[i]); end
    end
  endtask

  task automatic test_flush();
    drain_delay = 1;
    do_reset(1'b1);
    push_run(100, 3);
    calib_done = 1'b0;
    s_valid = 1'b1;
    s_data = 64'hBAD;
    @(negedge clk);
    checks += 2;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL calib_drop_ready: got %b required 0", s_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL calib_drop_busy: got %b required 1", busy); end
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();
    checks++;
    if (cmd_q.size() != 0) begin errors++; $display("FAIL calib_hold_cmd: got %0d cmds required 0", cmd_q.size()); end
    s_valid = 1'b0;
    calib_done = 1'b1;
    wait_cmds(1);
    wait_ready();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push_run(103, 8);
    wait_cmds(2);
    if (cmd_q.size() == 2) begin
      checks += 4;
      if (cmd_q[0].addr !== 30'd0) begin errors++; $display("FAIL flush_addr: got %0d required 0", cmd_q[0].addr); end
      if (cmd_q[0].bl !== 6'd2) begin errors++; $display("FAIL flush_bl: got %0d required 2", cmd_q[0].bl); end
      if (cmd_q[1].addr !== 30'd24) begin errors++; $display("FAIL after_flush_addr: got %0d required 24", cmd_q[1].addr); end
      if (cmd_q[1].bl !== 6'd7) begin errors++; $display("FAIL empty_flush_bl: got %0d required 7", cmd_q[1].bl); end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== 64'(100 + i)) begin
        errors++;
        $display("FAIL flush_wr_data[%0d]: got %0d required %0d", i, (i < wr_q.size()) ? wr_q[i] : 64'hX, 100 + i);
      end
    end
    checks++;
    if (gap_q.size() < 1 || gap_q[0] !== 5) begin
      errors++;
      $display("FAIL guard_gap: got %0d required 5", (gap_q.size() > 0) ? gap_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    drain_delay = 1;
    do_reset(1'b1);
    push_run(200, 8);
    wait_cmds(1);
    push_run(208, 5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (c3_p0_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en: got %b required 0", c3_p0_wr_en); end
    if (c3_p0_cmd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd_en: got %b required 0", c3_p0_cmd_en); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", s_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    if (c3_p0_cmd_byte_addr !== 30'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d required 0", c3_p0_cmd_byte_addr); end
    if (c3_p0_wr_data !== 64'd0) begin errors++; $display("FAIL mid_rst_wr_data: got %0h required 0", c3_p0_wr_data); end
    cycle();
    reset = 1'b0;
    checks++;
    if (cmd_q.size() != 1) begin errors++; $display("FAIL mid_rst_no_cmd: got %0d cmds required 1", cmd_q.size()); end
    clear_mon();
    push_run(220, 8);
    wait_cmds(1);
    if (cmd_q.size() == 1) begin
      checks += 2;
      if (cmd_q[0].addr !== 30'd0) begin errors++; $display("FAIL post_rst_addr: got %0d required 0", cmd_q[0].addr); end
      if (cmd_q[0].bl !== 6'd7) begin errors++; $display("FAIL post_rst_bl: got %0d required 7", cmd_q[0].bl); end
    end
    checks++;
    if (wr_q.size() != 8 || wr_q[0] !== 64'd220) begin
      errors++;
      $display("FAIL post_rst_wr: got %0d words first %0d required 8 words first 220", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'hX);
    end
  endtask

  task automatic test_frame_start();
    logic [29:0] ea[3];
    ea = '{30'd0, 30'd64, 30'd0};
    drain_delay = 1;
    do_reset(1'b1);
    push_run(300, 8);
    push_run(308, 3);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    push_run(311, 5);
    push_run(316, 8);
    wait_cmds(3);
    for (int i = 0; i < cmd_q.size() && i < 3; i++) begin
      checks += 3;
      if (cmd_q[i].addr !== ea[i]) begin errors++; $display("FAIL fstart_addr[%0d]: got %0d required %0d", i, cmd_q[i].addr, ea[i]); end
      if (cmd_q[i].bl !== 6'd7) begin errors++; $display("FAIL fstart_bl[%0d]: got %0d required 7", i, cmd_q[i].bl); end
      if (cmd_q[i].fd !== 1'b0) begin errors++; $display("FAIL fstart_frame_done[%0d]: got %b required 0", i, cmd_q[i].fd); end
    end
  endtask

  initial begin
    test_reset();
    test_no_calib();
    test_frame();
    test_flush();
    test_reset_mid();
    test_frame_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mig_p0_write_burster.md
Name: mig_p0_write_burster

Overview:
- Upstream feeder for the DDR2 MIG wrapper's port 0 write path.
- Accepts a valid/ready stream of 64-bit pixel words from the Mandelbrot render pipeline and pushes them into the p0 write-data FIFO.
- Issues one write command per burst, with auto-incrementing byte address and wrap at the end of the frame buffer.
- Gates all traffic on calibration and waits for the MIG write FIFO to drain between bursts.

Parameters:
- BURST_LEN, 32, words per full burst; legal range 1..64.
- BASE_ADDR, 0, byte address of the first frame word; must be 8-byte aligned.
- FRAME_WORDS, 38400, 64-bit words per frame (640x480 at 8 bpp).
- DRAIN_GUARD, 4, minimum cycles after cmd_en before wr_count is trusted.

Ports:
- clk  in  1  system clock, shared with the MIG user ports.
- reset  in  1  synchronous, active-high.
- calib_done  in  1  MIG calibration complete.
- frame_start  in  1  pulse: restart the frame at BASE_ADDR.
- flush  in  1  pulse: issue a partially filled burst.
- s_valid  in  1  input word valid.
- s_data  in  64  input word.
- s_ready  out  1  block accepts the word this cycle.
- c3_p0_wr_en  out  1  MIG write FIFO push.
- c3_p0_wr_data  out  64  MIG write data.
- c3_p0_wr_mask  out  8  tied 8'h00.
- c3_p0_wr_count  in  7  MIG write FIFO occupancy.
- c3_p0_cmd_en  out  1  MIG command push.
- c3_p0_cmd_instr  out  3  always 3'b000 (write).
- c3_p0_cmd_bl  out  6  burst length minus one.
- c3_p0_cmd_byte_addr  out  30  burst start byte address.
- busy  out  1  burst in progress (state != IDLE).
- frame_done  out  1  1-cycle pulse when the frame's final burst is issued.

Behaviour:
- Reset: all outputs 0 except c3_p0_cmd_byte_addr = BASE_ADDR; state IDLE; word counters 0; pending flags cleared. Reset mid-burst abandons the burst with no cmd_en. Words already pushed to the MIG are the MIG's concern.
- States:
  - IDLE -> FILL when calib_done=1.
  - FILL -> LAST when the burst is terminated.
  - LAST -> CMD after 1 cycle.
  - CMD -> DRAIN after 1 cycle.
  - DRAIN -> FILL when the guard expires and wr_count==0.
- s_ready = 1 only in FILL with calib_done=1 and n < limit, where n = words in the current burst.
- Accept = s_valid & s_ready.
- Write path is registered: an accepted word appears on c3_p0_wr_en/wr_data the next cycle. Exactly 1 wr_en per accepted word, in order.
- Burst termination, evaluated in FILL:
  - n reaches limit. limit = min(BURST_LEN, FRAME_WORDS - frame_words_done).
  - Or flush (pending) with n>0.
- Flush with n==0 is discarded.
- The last accepted word's wr_en occurs in LAST; the command is issued one cycle later, so data is always in the FIFO before its command.
- CMD: cmd_en=1 for exactly 1 cycle, bl = n-1, byte_addr = current address.
- Address update in CMD:
  - Next address = addr + 8*n and frame_words_done += n.
  - If frame_words_done reaches FRAME_WORDS: address <= BASE_ADDR, frame_words_done <= 0, frame_done=1 in the same cycle as cmd_en.
- DRAIN: s_ready=0. Count DRAIN_GUARD cycles from entry, then leave when c3_p0_wr_count==0.
- calib_done falling in FILL: s_ready=0 immediately. Buffered words are held; the state machine resumes when calib_done returns.
- frame_start:
  - In FILL with n==0 or in IDLE: address <= BASE_ADDR and frame_words_done <= 0 immediately.
  - Otherwise latched as pending and applied in CMD, overriding the computed next address.
- frame_start and flush in the same cycle: flush is applied to the current burst, then the frame restart.
- Address width: 30 bits; the increment never exceeds BASE_ADDR + 8*FRAME_WORDS.

Decomposition:
- Shared package mig_pkg:
  - MIG instruction constants: WR=3'b000, RD=3'b001, WR_AP, RD_AP.
  - Port widths: DATA_W=64, MASK_W=8, ADDR_W=30, BL_W=6, CNT_W=7.
  - Burster state enum.
- Single module; no sub-module. The drain/guard counter and address generator are inline.

Test Plan:
- calib_done=0, s_valid=1 for 100 cycles -> s_ready=0, no wr_en or cmd_en.
- BURST_LEN=8, calib_done=1, words 20..27 -> 8 wr_en with data 20..27, then one cmd_en with instr 000, bl=7, addr=0. s_ready=0 until the MIG model reports wr_count=0 and at least 4 cycles have elapsed.
- Second burst 28..35 -> cmd_en with bl=7, addr=64.
- 3 words then a flush pulse -> cmd_en with bl=2 at the current address; the next burst starts 24 bytes later.
- FRAME_WORDS=20, BURST_LEN=8 -> bursts at addr 0/64/128 with bl 7/7/3; frame_done coincides with the third cmd_en; the fourth burst starts at addr 0.
- Reset after 5 words in FILL -> next cycle all outputs 0, no cmd_en; first post-reset burst at BASE_ADDR.
- frame_start mid-burst -> the burst completes at its own address; the following burst is at BASE_ADDR.
